map_sequencer: RTL and testbench

MAP_SEQUENCER -- requirements
Module: map_sequencer

---
 rtl/map_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_map_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_sequencer.sv
// ---------------------------------------------------------------------------
// map_sequencer
//
// Walks the 64 IFFT bins of one OFDM symbol and tells the constellation
// mapper what goes into each bin: a null subcarrier, a pilot, or the next
// data bit group taken from upstream.
//
// Bin plan (k = IFFT bin):
//   null  : k = 0 and k = 27..37   (12 bins, map_data = 0, is_zero = 1)
//   pilot : k = 7, 21, 43, 57      (4 bins, map_data = 0, is_pilot = 1)
//   data  : the remaining 48 bins  (map_data = in_data)
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   start           one-cycle pulse, begin one symbol (IDLE only)
//   bpsc_in [2:0]   bits per subcarrier, legal values 1,2,4,6
//   in_valid        upstream bit group valid
//   in_data [5:0]   upstream bit group, LSB aligned
//   in_ready        combinational: a data bin is waiting for in_data
//   map_en          registered: a bin is presented this cycle
//   map_data [5:0]  registered bit group for the mapper
//   map_bpsc [2:0]  bpsc latched at the accepted start
//   is_zero         registered: null bin
//   is_pilot        registered: pilot bin
//   pilot_indicator registered: 1 = +2048, 0 = -2048 (pilot bins only)
//   sc_idx [5:0]    registered IFFT bin of the presented output
//   sym_last        registered: high together with bin 63
//   busy            registered: symbol in progress
//   bpsc_err        registered one-cycle pulse: start rejected (bad bpsc)
//
// Configuration macro: MAPSEQ_PILOT_POLARITY_EN
//   defined   : pilot polarity follows the x^7+x^4+1 scrambler sequence,
//               seeded 7'h7F and stepped once per completed symbol.
//   undefined : no polarity register; polarity is always positive.
// ---------------------------------------------------------------------------
module map_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] bpsc_in,
  input  logic       in_valid,
  input  logic [5:0] in_data,
  output logic       in_ready,
  output logic       map_en,
  output logic [5:0] map_data,
  output logic [2:0] map_bpsc,
  output logic       is_zero,
  output logic       is_pilot,
  output logic       pilot_indicator,
  output logic [5:0] sc_idx,
  output logic       sym_last,
  output logic       busy,
  output logic       bpsc_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_r;
  logic [5:0] k_r;

  logic null_s;
  logic pilot_s;
  logic data_s;
  logic live_s;
  logic advance_s;
  logic pn_s;
  logic ind_s;

  // ---- bin classification helpers ----
  function automatic logic bin_is_null(input logic [5:0] k);
    return (k == 6'd0) || ((k >= 6'd27) && (k <= 6'd37));
  endfunction

  function automatic logic bin_is_pilot(input logic [5:0] k);
    return (k == 6'd7) || (k == 6'd21) || (k == 6'd43) || (k == 6'd57);
  endfunction

  // Nominal pilot sign before polarity: bin 21 is the only negative pilot.
  function automatic logic pilot_base(input logic [5:0] k);
    return (k != 6'd21);
  endfunction

  function automatic logic bpsc_legal(input logic [2:0] b);
    logic ok;
    case (b)
      3'd1, 3'd2, 3'd4, 3'd6: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef MAPSEQ_PILOT_POLARITY_EN
  logic [6:0] lfsr_r;
  logic       pol_s;

  // Polarity bit of the current symbol is the scrambler feedback value.
  assign pol_s = lfsr_r[6] ^ lfsr_r[3];

  // Polarity scrambler: steps once, in the cycle that closes a symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 7'h7F;
    end else if ((state_r == RUN) && sym_last) begin
      lfsr_r <= {lfsr_r[5:0], pol_s};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  logic pol_s;

  assign pol_s = 1'b0;
`endif

  // Bin classification, handshake and pilot sign for the current bin.
  always_comb begin
    null_s  = bin_is_null(k_r);
    pilot_s = bin_is_pilot(k_r);
    data_s  = !null_s && !pilot_s;
    // The sym_last cycle is the closing cycle of RUN: nothing more is taken.
    live_s  = (state_r == RUN) && !sym_last;
    in_ready = live_s && data_s;
    if (live_s) begin
      advance_s = data_s ? in_valid : 1'b1;
    end else begin
      advance_s = 1'b0;
    end
    pn_s  = ~pol_s;
    ind_s = pilot_base(k_r) ~^ pn_s;
  end

  // Sequencer FSM with all mapper-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      k_r             <= 6'd0;
      map_en          <= 1'b0;
      map_data        <= 6'd0;
      map_bpsc        <= 3'd0;
      is_zero         <= 1'b0;
      is_pilot        <= 1'b0;
      pilot_indicator <= 1'b0;
      sc_idx          <= 6'd0;
      sym_last        <= 1'b0;
      busy            <= 1'b0;
      bpsc_err        <= 1'b0;
    end else begin
      // Strobes are low unless a bin is emitted below.
      map_en          <= 1'b0;
      is_zero         <= 1'b0;
      is_pilot        <= 1'b0;
      pilot_indicator <= 1'b0;
      sym_last        <= 1'b0;
      bpsc_err        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (bpsc_legal(bpsc_in)) begin
              state_r  <= RUN;
              map_bpsc <= bpsc_in;
              k_r      <= 6'd0;
              busy     <= 1'b1;
            end else begin
              bpsc_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (sym_last) begin
            // Bin 63 is on the outputs now; close the symbol.
            state_r <= IDLE;
            busy    <= 1'b0;
            k_r     <= 6'd0;
          end else if (advance_s) begin
            map_en          <= 1'b1;
            sc_idx          <= k_r;
            is_zero         <= null_s;
            is_pilot        <= pilot_s;
            map_data        <= data_s ? in_data : 6'd0;
            pilot_indicator <= pilot_s & ind_s;
            sym_last        <= (k_r == 6'd63);
            // k parks on 63 until the closing cycle clears it.
            if (k_r != 6'd63) begin
              k_r <= k_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          k_r     <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_sequencer.sv
// ---------------------------------------------------------------------------
// tb_map_sequencer
//
// Randomised bench for map_sequencer. For every symbol the driver builds the
// expected 64-bin output list from the bin plan (null/pilot/data), the data
// words it is about to offer, and the pilot polarity of that symbol number.
// Polarity is produced from the scrambler recurrence y[n] = y[n-7] ^ y[n-4]
// over a bit array. A forked monitor pops one entry per map_en and compares.
// ---------------------------------------------------------------------------
module tb_map_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] bpsc_in;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       map_en;
  logic [5:0] map_data;
  logic [2:0] map_bpsc;
  logic       is_zero;
  logic       is_pilot;
  logic       pilot_indicator;
  logic [5:0] sc_idx;
  logic       sym_last;
  logic       busy;
  logic       bpsc_err;

  map_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .bpsc_in         (bpsc_in),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .map_en          (map_en),
    .map_data        (map_data),
    .map_bpsc        (map_bpsc),
    .is_zero         (is_zero),
    .is_pilot        (is_pilot),
    .pilot_indicator (pilot_indicator),
    .sc_idx          (sc_idx),
    .sym_last        (sym_last),
    .busy            (busy),
    .bpsc_err        (bpsc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit zero;
    bit pilot;
    int data;
    bit ind;
    bit last;
    int bpsc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   sym_model;
  bit   pol_seq[0:126];
  int   cur_words[48];
  int   w;

  // monitor results
  int   mon_sym;
  bit   ind7_rec[0:15];
  bit   ind21_rec[0:15];
  int   last_span;
  int   last_gaps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic bit sym_pol(input int s);
`ifdef MAPSEQ_PILOT_POLARITY_EN
    return pol_seq[s % 127];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_map_en"},   32'(map_en), 0);
    chk({tag, "_map_data"}, 32'(map_data), 0);
    chk({tag, "_map_bpsc"}, 32'(map_bpsc), 0);
    chk({tag, "_is_zero"},  32'(is_zero), 0);
    chk({tag, "_is_pilot"}, 32'(is_pilot), 0);
    chk({tag, "_pilot_ind"}, 32'(pilot_indicator), 0);
    chk({tag, "_sc_idx"},   32'(sc_idx), 0);
    chk({tag, "_sym_last"}, 32'(sym_last), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_bpsc_err"}, 32'(bpsc_err), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  task automatic monitor();
    exp_t e;
    bit   in_sym;
    int   span, gaps, zc, pc, dc;
    in_sym = 0; span = 0; gaps = 0; zc = 0; pc = 0; dc = 0;
    forever begin
      @(negedge clk);
      if (map_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_map_en", 32'(sc_idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sc_idx",    32'(sc_idx), 32'(e.idx));
          chk("is_zero",   32'(is_zero), 32'(e.zero));
          chk("is_pilot",  32'(is_pilot), 32'(e.pilot));
          chk("map_data",  32'(map_data), 32'(e.data));
          chk("pilot_ind", 32'(pilot_indicator), 32'(e.ind));
          chk("sym_last",  32'(sym_last), 32'(e.last));
          chk("map_bpsc",  32'(map_bpsc), 32'(e.bpsc));
        end
        if (is_zero) zc++;
        else if (is_pilot) pc++;
        else dc++;
        if (mon_sym < 16 && sc_idx == 6'd7)  ind7_rec[mon_sym]  = pilot_indicator;
        if (mon_sym < 16 && sc_idx == 6'd21) ind21_rec[mon_sym] = pilot_indicator;
        if (!in_sym) begin
          in_sym = 1; span = 0; gaps = 0;
        end
      end else begin
        chk("idle_strobes", 32'({is_zero, is_pilot, sym_last}), 0);
        if (in_sym) gaps++;
      end
      if (in_sym) span++;
      if (map_en && sym_last) begin
        chk("null_count",  32'(zc), 12);
        chk("pilot_count", 32'(pc), 4);
        chk("data_count",  32'(dc), 48);
        last_span = span;
        last_gaps = gaps;
        in_sym = 0; zc = 0; pc = 0; dc = 0;
        mon_sym++;
      end
      if (rst) begin
        exp_q.delete();
        in_sym = 0; zc = 0; pc = 0; dc = 0;
        mon_sym = 0;
      end
    end
  endtask

  // mode 0: random in_valid + mid-symbol start; 1: in_valid always 1;
  // 2: in_valid low for 5 cycles at bin 1. rst_bin >= 0 aborts by reset.
  task automatic run_symbol(input int b, input int mode, input int rst_bin, input bit end_start);
    bit   done, hs, aborted;
    bit   pol;
    int   j;
    exp_t e;
    pol = sym_pol(sym_model);
    j = 0;
    for (int i = 0; i < 48; i++) cur_words[i] = int'($urandom_range(0, 63));
    for (int k = 0; k < 64; k++) begin
      e.idx   = k;
      e.zero  = (k == 0) || (k >= 27 && k <= 37);
      e.pilot = (k == 7) || (k == 21) || (k == 43) || (k == 57);
      e.last  = (k == 63);
      e.bpsc  = b;
      // pn is +1 when the polarity bit is 0; indicator = base XNOR pn
      e.ind   = e.pilot ? ((k != 21) == (pol == 1'b0)) : 1'b0;
      if (e.zero || e.pilot) e.data = 0;
      else begin
        e.data = cur_words[j];
        j++;
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; bpsc_in = 3'(b); in_valid = 1'b0; w = 0;
    @(posedge clk); #1;
    start = 1'b0;
    done = 0; aborted = 0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (mode == 0 && cyc == 10) begin
        start = 1'b1; bpsc_in = 3'($urandom_range(0, 7));
      end
      case (mode)
        1:       in_valid = 1'b1;
        2:       in_valid = !(cyc >= 1 && cyc <= 5);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = (w < 48) ? 6'(cur_words[w]) : 6'($urandom_range(0, 63));
      @(negedge clk);
      hs = in_valid && in_ready;
      if (mode == 0 && cyc == 11) chk("start_in_run_no_err", 32'(bpsc_err), 0);
      if (sym_last) begin
        done = 1;
        if (end_start) begin
          start = 1'b1; bpsc_in = 3'd4;
        end
      end
      if (rst_bin >= 0 && map_en && int'(sc_idx) == rst_bin) begin
        done = 1; aborted = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) w++;
    end
    in_valid = 1'b0;
    if (!done) begin
      chk("symbol_timeout", 0, 1);
      exp_q.delete();
    end else if (aborted) begin
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      sym_model = 0;
      @(negedge clk);
      check_all_zero("mid_reset");
    end else begin
      sym_model++;
      if (end_start) begin
        @(negedge clk);
        chk("start_on_last_busy1", 32'(busy), 0);
        @(negedge clk);
        chk("start_on_last_busy2", 32'(busy), 0);
        chk("start_on_last_map_en", 32'(map_en), 0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit   y[0:140];
    logic [7:0] exp7;
    int   legal[4];
    legal = '{1, 2, 4, 6};
    for (int n = 0; n < 7; n++) y[n] = 1'b1;
    for (int n = 7; n < 141; n++) y[n] = y[n-7] ^ y[n-4];
    for (int n = 0; n < 127; n++) pol_seq[n] = y[n+7];
`ifdef MAPSEQ_PILOT_POLARITY_EN
    exp7 = 8'b1000_1111;
`else
    exp7 = 8'b1111_1111;
`endif
    checks = 0; errors = 0; sym_model = 0; mon_sym = 0; w = 0;
    last_span = 0; last_gaps = 0;
    rst = 1'b1; start = 1'b0; bpsc_in = 3'd0; in_valid = 1'b0; in_data = 6'd0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // illegal bpsc
    @(posedge clk); #1;
    start = 1'b1; bpsc_in = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bpsc_err_pulse", 32'(bpsc_err), 1);
    chk("bpsc_err_busy", 32'(busy), 0);
    @(negedge clk);
    chk("bpsc_err_one_cycle", 32'(bpsc_err), 0);
    chk("bpsc_err_busy2", 32'(busy), 0);

    // eight back-to-back symbols
    run_symbol(2, 1, -1, 1'b0);
    for (int s = 1; s < 8; s++) run_symbol(legal[$urandom_range(0, 3)], 0, -1, s == 4);
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("bin7_pol_sym%0d", s), 32'(ind7_rec[s]), 32'(exp7[s]));
      chk($sformatf("bin21_pol_sym%0d", s), 32'(ind21_rec[s]), 32'(!exp7[s]));
    end

    // 5-cycle stall at bin 1
    run_symbol(6, 2, -1, 1'b0);
    chk("stall_span", 32'(last_span), 69);
    chk("stall_gaps", 32'(last_gaps), 5);

    // reset at bin 30, then polarity re-seeded
    run_symbol(4, 1, 30, 1'b0);
    run_symbol(1, 1, -1, 1'b0);
    chk("reseed_bin7", 32'(ind7_rec[0]), 1);
    chk("reseed_bin21", 32'(ind21_rec[0]), 0);

    for (int s = 0; s < 3; s++) run_symbol(legal[$urandom_range(0, 3)], 0, -1, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
